vmem_burst_sequencer: RTL and testbench
=======================================

Name: vmem_burst_sequencer

Overview:
- Accepts one vector load/store command at a time: base address, byte stride, beat count.
- Sequences that command into the vector memory queue as a burst of 64-bit beats, one address/data push per cycle.
- Waits for the queue's load-done or store-done indication, then reports completion.
- Sits between the vector unit's load/store issue logic and the memory queue that bridges to the 32-bit AXI-style bus.

Parameters:
- ADDR_WIDTH, 32, address width of command and queue address port.
- DATA_WIDTH, 64, vector beat width; must equal the queue's vector data width.
- LEN_BITS, 9, width of beat count; cmd_len max is 2^LEN_BITS-1 and must be below the queue FIFO depth.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with VMEMSEQ_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_store  in  1  1 = store, 0 = load
- cmd_addr  in  ADDR_WIDTH  base byte address
- cmd_stride  in  ADDR_WIDTH  byte stride between beats, two's complement
- cmd_len  in  LEN_BITS  beat count; 0 = no-op
- st_data  in  DATA_WIDTH  store beat data from vector register file
- st_valid  in  1  store beat available
- st_ready  out  1  store beat consumed this cycle when st_valid & st_ready
- ld_ready  in  1  vector register file can accept load data
- q_addr  out  ADDR_WIDTH  beat address to queue
- q_req  out  1  load address push
- q_valid  out  1  store data push
- q_start  out  1  first store beat of a burst
- q_data  out  DATA_WIDTH  store beat data
- q_be  out  DATA_WIDTH/8  byte enables
- q_ready  out  1  load-data ready to queue
- q_done_ld  in  1  queue load burst complete
- q_done_st  in  1  queue store burst acked
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. State is IDLE. Counters and address registers are 0.
- States: IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE, ST_WAIT, FIN.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - On cmd_valid with cmd_len≠0: latch cur_addr=cmd_addr, stride, remaining=cmd_len. Go to LD_ISSUE or ST_ISSUE per cmd_store.
  - On cmd_valid with cmd_len=0: go to FIN. No queue traffic.
- LD_ISSUE:
  - Every cycle: q_req=1, q_addr=cur_addr; cur_addr+=stride; remaining-=1.
  - Go to LD_WAIT when the beat with remaining=1 is issued. Exactly cmd_len consecutive q_req cycles.
- LD_WAIT: q_ready=ld_ready. On q_done_ld=1 go to FIN.
- q_ready is 0 in every state other than LD_WAIT.
- ST_ISSUE:
  - st_ready=1.
  - Beat fires when st_valid: q_valid=1, q_addr=cur_addr, q_data=st_data; q_start=1 on the first beat only. Then advance cur_addr and decrement remaining.
  - st_valid=0 stalls with no push and address held.
  - After the last beat go to ST_WAIT.
- ST_WAIT: on q_done_st=1 go to FIN.
- FIN: done=1 for one cycle, then IDLE. A new command is accepted no earlier than the cycle after FIN.
- busy=1 in every state except IDLE.
- q_be is all ones whenever q_valid=1, else 0.
- q_addr is 0 when neither q_req nor q_valid is asserted.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap past the top is silent. A negative stride decrements.
- Done inputs are level-sensitive and sampled only in the matching WAIT state. A done input asserted in any other state is ignored.
- cmd_valid while busy is not accepted; the command must be held by the requester.
- Reset mid-operation: immediate return to IDLE, outputs to reset values, in-flight beats abandoned. The queue must be reset in the same cycle.

Optional Feature:
- VMEMSEQ_TIMEOUT_EN defined:
  - A counter clears on entry to LD_WAIT or ST_WAIT and increments each cycle there.
  - Reaching TIMEOUT_CYCLES: err=1 for one cycle, done stays 0, return to IDLE.
- Not defined: no counter; err tied 0; WAIT states wait indefinitely.

Test Plan:
- Load, addr=0x1000, stride=8, len=4, ld_ready=1 -> q_req high 4 consecutive cycles, q_addr 0x1000,0x1008,0x1010,0x1018; q_done_ld 3 cycles later -> done pulse next cycle, cmd_ready back.
- Store, addr=0x2000, stride=-16, len=3, st_valid toggling 1,0,1,1 -> q_valid on 3 cycles, q_addr 0x2000,0x1FF0,0x1FE0, q_start only on first, q_be=0xFF; done after q_done_st.
- len=0 command -> no q_req/q_valid, done pulses on the cycle after acceptance.
- Address wrap, addr=0xFFFFFFF8, stride=8, len=2 -> q_addr 0xFFFFFFF8 then 0x00000000.
- rst_n low during LD_ISSUE beat 2 of 5 -> next cycle all outputs 0, cmd_ready=1; a fresh command then issues from its own base.
- With VMEMSEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, q_done_st never asserted -> err pulses 16 cycles after entering ST_WAIT, done stays 0, returns to IDLE.

Source files
------------

// File: rtl/vmem_burst_sequencer.sv
// Vector load/store burst sequencer: turns one strided command into 64-bit beat pushes to the
// memory queue and reports completion. Define VMEMSEQ_TIMEOUT_EN to enable the WAIT-state watchdog.
module vmem_burst_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned LEN_BITS       = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_store,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_stride,
  input  logic [LEN_BITS-1:0]     i_cmd_len,
  input  logic [DATA_WIDTH-1:0]   i_st_data,
  input  logic                    i_st_valid,
  output logic                    o_st_ready,
  input  logic                    i_ld_ready,
  output logic [ADDR_WIDTH-1:0]   o_q_addr,
  output logic                    o_q_req,
  output logic                    o_q_valid,
  output logic                    o_q_start,
  output logic [DATA_WIDTH-1:0]   o_q_data,
  output logic [DATA_WIDTH/8-1:0] o_q_be,
  output logic                    o_q_ready,
  input  logic                    i_q_done_ld,
  input  logic                    i_q_done_st,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  typedef enum logic [2:0] {
    StIdle, StLdIssue, StLdWait, StStIssue, StStWait, StFin
  } state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [LEN_BITS-1:0]   r_remaining;
  logic                  r_first;
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_q_req;
  logic                  r_st_ready;
  logic                  w_st_fire;
  logic                  w_in_wait;
  logic                  w_timeout;
  logic                  w_last;

  assign w_st_fire = r_st_ready & i_st_valid;
  assign w_in_wait = (r_state == StLdWait) || (r_state == StStWait);
  assign w_last    = (r_remaining == LEN_BITS'(1));

`ifdef VMEMSEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] r_wait_cnt;
  logic            r_err;

  assign w_timeout = (r_wait_cnt == CntW'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero outside the WAIT states, so it is clear on every WAIT entry.
  always_ff @(posedge clk) begin
    if (!rst_n || !w_in_wait) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
      r_err      <= w_timeout &&
                    !((r_state == StLdWait) ? i_q_done_ld : i_q_done_st);
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cur_addr  <= '0;
      r_stride    <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_q_req     <= 1'b0;
      r_st_ready  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (i_cmd_len == '0) begin
              r_state <= StFin;
              r_done  <= 1'b1;
            end else begin
              r_cur_addr  <= i_cmd_addr;
              r_stride    <= i_cmd_stride;
              r_remaining <= i_cmd_len;
              r_first     <= 1'b1;
              if (i_cmd_store) begin
                r_state    <= StStIssue;
                r_st_ready <= 1'b1;
              end else begin
                r_state <= StLdIssue;
                r_q_req <= 1'b1;
              end
            end
          end
        end
        StLdIssue: begin
          r_cur_addr  <= r_cur_addr + r_stride;
          r_remaining <= r_remaining - 1'b1;
          if (w_last) begin
            r_state <= StLdWait;
            r_q_req <= 1'b0;
          end
        end
        StStIssue: begin
          if (i_st_valid) begin
            r_cur_addr  <= r_cur_addr + r_stride;
            r_remaining <= r_remaining - 1'b1;
            r_first     <= 1'b0;
            if (w_last) begin
              r_state    <= StStWait;
              r_st_ready <= 1'b0;
            end
          end
        end
        StLdWait, StStWait: begin
          if ((r_state == StLdWait) ? i_q_done_ld : i_q_done_st) begin
            r_state <= StFin;
            r_done  <= 1'b1;
          end else if (w_timeout) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        StFin: begin
          r_state     <= StIdle;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_q_req     = r_q_req;
  assign o_st_ready  = r_st_ready;
  assign o_q_valid   = w_st_fire;
  assign o_q_start   = w_st_fire & r_first;
  assign o_q_data    = w_st_fire ? i_st_data : '0;
  assign o_q_be      = w_st_fire ? {(DATA_WIDTH/8){1'b1}} : '0;
  assign o_q_addr    = (r_q_req | w_st_fire) ? r_cur_addr : '0;
  assign o_q_ready   = (r_state == StLdWait) & i_ld_ready;

endmodule

// File: tb/tb_vmem_burst_sequencer.sv
// Randomized self-checking bench for vmem_burst_sequencer; expected beat addresses come from
// base + i*stride arithmetic and expected timing from the command-level protocol.
module tb_vmem_burst_sequencer;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LB = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cmd_valid, i_cmd_store, i_st_valid, i_ld_ready, i_q_done_ld, i_q_done_st;
  logic [AW-1:0] i_cmd_addr, i_cmd_stride;
  logic [LB-1:0] i_cmd_len;
  logic [DW-1:0] i_st_data;
  logic          o_cmd_ready, o_st_ready, o_q_req, o_q_valid, o_q_start, o_q_ready;
  logic          o_busy, o_done, o_err;
  logic [AW-1:0] o_q_addr;
  logic [DW-1:0] o_q_data;
  logic [7:0]    o_q_be;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vmem_burst_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_BITS(LB), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_store(i_cmd_store),
    .i_cmd_addr(i_cmd_addr), .i_cmd_stride(i_cmd_stride), .i_cmd_len(i_cmd_len),
    .i_st_data(i_st_data), .i_st_valid(i_st_valid), .o_st_ready(o_st_ready),
    .i_ld_ready(i_ld_ready), .o_q_addr(o_q_addr), .o_q_req(o_q_req), .o_q_valid(o_q_valid),
    .o_q_start(o_q_start), .o_q_data(o_q_data), .o_q_be(o_q_be), .o_q_ready(o_q_ready),
    .i_q_done_ld(i_q_done_ld), .i_q_done_st(i_q_done_st),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    i_cmd_valid = 0; i_cmd_store = 0; i_cmd_addr = '0; i_cmd_stride = '0; i_cmd_len = '0;
    i_st_data = '0; i_st_valid = 0; i_ld_ready = 0; i_q_done_ld = 0; i_q_done_st = 0;
  endtask

  // Drives one command end to end and checks every beat and the completion handshake.
  task automatic run_cmd(input bit store, input logic [AW-1:0] addr, input logic [AW-1:0] stride,
                         input int len, input bit use_pat, input logic [15:0] pat,
                         input int done_dly);
    logic [AW-1:0] exp_addr;
    int            pushes, cyc;
    bit            sv;
    @(negedge clk);
    cyc = 0;
    while (!o_cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    n_tests++; if (o_cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL cmd_ready_before: got %b exp 1", o_cmd_ready); end
    i_cmd_valid = 1; i_cmd_store = store; i_cmd_addr = addr; i_cmd_stride = stride;
    i_cmd_len = LB'(len);
    @(negedge clk);
    i_cmd_valid = 0;
    n_tests++; if (o_busy !== 1'b1 || o_cmd_ready !== 1'b0) begin n_fail++;
      $display("FAIL busy_after_accept: got busy=%b rdy=%b exp 1/0", o_busy, o_cmd_ready); end
    if (len == 0) begin
      n_tests++; if (o_done !== 1'b1 || o_q_req !== 1'b0 || o_q_valid !== 1'b0) begin n_fail++;
        $display("FAIL len0_done: got done=%b req=%b val=%b exp 1/0/0", o_done, o_q_req,
                 o_q_valid); end
      @(negedge clk);
      n_tests++; if (o_done !== 1'b0 || o_cmd_ready !== 1'b1) begin n_fail++;
        $display("FAIL len0_after: got done=%b rdy=%b exp 0/1", o_done, o_cmd_ready); end
      return;
    end
    if (!store) begin
      for (int i = 0; i < len; i++) begin
        exp_addr = addr + stride * AW'(i);
        i_ld_ready = 1'($urandom); i_q_done_ld = 1'($urandom); i_q_done_st = 1'($urandom);
        #1;
        n_tests++; if (o_q_req !== 1'b1 || o_q_addr !== exp_addr || o_q_valid !== 1'b0 ||
                       o_q_ready !== 1'b0) begin n_fail++;
          $display("FAIL ld_beat%0d: got req=%b addr=%h val=%b qrdy=%b exp 1/%h/0/0", i, o_q_req,
                   o_q_addr, o_q_valid, o_q_ready, exp_addr); end
        @(negedge clk);
      end
    end else begin
      pushes = 0; cyc = 0;
      while (pushes < len && cyc < 64) begin
        sv = (use_pat && cyc < 16) ? pat[cyc] : 1'($urandom);
        i_st_valid = sv; i_st_data = {$urandom, $urandom};
        i_q_done_ld = 1'($urandom); i_q_done_st = 1'($urandom);
        exp_addr = sv ? addr + stride * AW'(pushes) : '0;
        #1;
        n_tests++; if (o_st_ready !== 1'b1 || o_q_valid !== sv || o_q_req !== 1'b0 ||
                       o_q_addr !== exp_addr || o_q_data !== (sv ? i_st_data : '0) ||
                       o_q_be !== (sv ? 8'hff : 8'h00) ||
                       o_q_start !== (sv && pushes == 0)) begin n_fail++;
          $display("FAIL st_cycle%0d: got srdy=%b val=%b addr=%h data=%h be=%h start=%b exp val=%b addr=%h",
                   cyc, o_st_ready, o_q_valid, o_q_addr, o_q_data, o_q_be, o_q_start, sv,
                   exp_addr); end
        pushes += int'(sv); cyc++;
        @(negedge clk);
      end
      n_tests++; if (pushes != len) begin n_fail++;
        $display("FAIL st_push_budget: got %0d pushes exp %0d", pushes, len); end
    end
    for (int k = 0; k <= done_dly; k++) begin
      i_ld_ready = 1'($urandom); i_st_valid = 1'($urandom);
      i_q_done_ld = store ? 1'($urandom) : (k == done_dly);
      i_q_done_st = store ? (k == done_dly) : 1'($urandom);
      #1;
      n_tests++; if (o_q_req !== 1'b0 || o_q_valid !== 1'b0 || o_st_ready !== 1'b0 ||
                     o_q_ready !== (!store && i_ld_ready) || o_done !== 1'b0 ||
                     o_busy !== 1'b1 || o_err !== 1'b0) begin n_fail++;
        $display("FAIL wait%0d: got req=%b val=%b srdy=%b qrdy=%b done=%b busy=%b err=%b",
                 k, o_q_req, o_q_valid, o_st_ready, o_q_ready, o_done, o_busy, o_err); end
      @(negedge clk);
    end
    i_q_done_ld = 0; i_q_done_st = 0; i_st_valid = 0; i_ld_ready = 0;
    n_tests++; if (o_done !== 1'b1 || o_cmd_ready !== 1'b0) begin n_fail++;
      $display("FAIL done_pulse: got done=%b rdy=%b exp 1/0", o_done, o_cmd_ready); end
    @(negedge clk);
    n_tests++; if (o_done !== 1'b0 || o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin n_fail++;
      $display("FAIL back_idle: got done=%b rdy=%b busy=%b exp 0/1/0", o_done, o_cmd_ready,
               o_busy); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; i_ld_ready = 1; i_st_valid = 1; i_st_data = 64'hdead_beef_0123_4567;
    repeat (3) @(negedge clk);
    n_tests++; if ({o_busy, o_done, o_err, o_q_req, o_q_valid, o_q_start, o_q_ready, o_st_ready}
                   !== 8'h00 || o_cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ctrl: got %b rdy=%b exp 00000000/1", {o_busy, o_done, o_err, o_q_req,
               o_q_valid, o_q_start, o_q_ready, o_st_ready}, o_cmd_ready); end
    n_tests++; if (o_q_addr !== '0 || o_q_data !== '0 || o_q_be !== '0) begin n_fail++;
      $display("FAIL reset_data: got addr=%h data=%h be=%h exp 0", o_q_addr, o_q_data, o_q_be); end
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_directed();
    run_cmd(1'b0, 32'h0000_1000, 32'd8, 4, 1'b0, 16'h0, 3);
    run_cmd(1'b1, 32'h0000_2000, -32'sd16, 3, 1'b1, 16'b1101, 2);
    run_cmd(1'b0, 32'h0000_0100, 32'd4, 0, 1'b0, 16'h0, 0);
    run_cmd(1'b0, 32'hffff_fff8, 32'd8, 2, 1'b0, 16'h0, 0);
    run_cmd(1'b1, 32'hffff_fff8, 32'd8, 2, 1'b1, 16'hffff, 1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_cmd_valid = 1; i_cmd_store = 0; i_cmd_addr = 32'h3000; i_cmd_stride = 32'd4; i_cmd_len = 5;
    @(negedge clk);
    i_cmd_valid = 0;
    @(negedge clk);
    n_tests++; if (o_q_req !== 1'b1 || o_q_addr !== 32'h3004) begin n_fail++;
      $display("FAIL mid_beat2: got req=%b addr=%h exp 1/00003004", o_q_req, o_q_addr); end
    rst_n = 0;
    @(negedge clk);
    n_tests++; if ({o_busy, o_done, o_q_req, o_q_valid, o_q_ready, o_st_ready} !== 6'b0 ||
                   o_q_addr !== '0 || o_cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL mid_reset: got busy=%b req=%b addr=%h rdy=%b exp 0/0/0/1", o_busy, o_q_req,
               o_q_addr, o_cmd_ready); end
    rst_n = 1;
    run_cmd(1'b0, 32'h5000, 32'd8, 3, 1'b0, 16'h0, 1);
  endtask

  task automatic test_random();
    logic [AW-1:0] addr, stride;
    for (int n = 0; n < 24; n++) begin
      addr = {$urandom} & ~32'h7;
      case ($urandom_range(0, 3))
        0: stride = 32'd8;
        1: stride = -32'sd8;
        2: stride = 32'($urandom_range(0, 256)) * 32'd8;
        default: stride = $urandom;
      endcase
      run_cmd(1'($urandom), addr, stride, $urandom_range(0, 9), 1'b0, 16'h0,
              $urandom_range(0, 4));
    end
  endtask

`ifdef VMEMSEQ_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    i_cmd_valid = 1; i_cmd_store = 1; i_cmd_addr = 32'h40; i_cmd_stride = 32'd8; i_cmd_len = 1;
    @(negedge clk);
    i_cmd_valid = 0; i_st_valid = 1;
    @(negedge clk);
    i_st_valid = 0;
    for (int k = 0; k < 16; k++) begin
      n_tests++; if (o_err !== 1'b0 || o_busy !== 1'b1) begin n_fail++;
        $display("FAIL to_wait%0d: got err=%b busy=%b exp 0/1", k, o_err, o_busy); end
      @(negedge clk);
    end
    n_tests++; if (o_err !== 1'b1 || o_done !== 1'b0 || o_cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL to_err: got err=%b done=%b rdy=%b exp 1/0/1", o_err, o_done, o_cmd_ready); end
    @(negedge clk);
    n_tests++; if (o_err !== 1'b0) begin n_fail++;
      $display("FAIL to_err_pulse: got err=%b exp 0", o_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
`ifdef VMEMSEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
